tcp_echo_responder: RTL

Parametrised TCP responder between the RX parser and TX parser in the simulation/DPI stack. Accepts parsed TCP segments, buffers them in a DEPTH-entry queue, and for each eligible segment emits one response segment with swapped IP/port tuple and a correct cumulative ACK. Unlike the single-register echo stage, it decouples RX from TX backpressure, acknowledges SYN/FIN sequence space, and keeps response/drop counters.

---
 rtl/tcp_echo_pkg.sv | 67 ++++++
 rtl/tcp_echo_fifo.sv | 62 ++++++
 rtl/tcp_echo_responder.sv | 129 ++++++++++++
 3 files changed

// File: rtl/tcp_echo_pkg.sv
// Shared types and constants for the TCP echo responder: wire-format header
// structs, the queued entry layout, fixed response field values, and the
// ACK-increment rule (payload bytes plus one each for SYN and FIN).
package tcp_echo_pkg;

   localparam int IP_ADDR_WIDTH                = 32;
   localparam int IP_HEADER_WIDTH              = 160;
   localparam int TCP_HEADER_WIDTH             = 160;
   localparam int PAYLOAD_BUF_ENTRY_ADDR_WIDTH = 16;
   localparam int PAYLOAD_BUF_ENTRY_LEN_WIDTH  = 16;
   localparam int IP_HEADER_BYTES              = 20;
   localparam int TCP_HEADER_BYTES             = 20;
   localparam int IPPROTO_TCP                  = 6;

   // TCP flag bit positions within the 8-bit flags field
   localparam int FLAG_FIN = 0;
   localparam int FLAG_SYN = 1;
   localparam int FLAG_PSH = 3;
   localparam int FLAG_ACK = 4;

   localparam logic [7:0]  RESP_FLAGS_CTRL = 8'h10;             // ACK
   localparam logic [7:0]  RESP_FLAGS_DATA = 8'h18;             // ACK|PSH
   localparam logic [15:0] RESP_IP_ID      = 16'd54321;
   localparam logic [15:0] RESP_HDR_BYTES  = 16'(IP_HEADER_BYTES + TCP_HEADER_BYTES);

   typedef struct packed {
      logic [3:0]  version;
      logic [3:0]  ihl;
      logic [7:0]  tos;
      logic [15:0] tot_len;
      logic [15:0] id;
      logic [15:0] frag_offset;
      logic [7:0]  ttl;
      logic [7:0]  protocol;
      logic [15:0] chksum;
      logic [31:0] src_addr;
      logic [31:0] dst_addr;
   } ip_hdr_t;

   typedef struct packed {
      logic [15:0] src_port;
      logic [15:0] dst_port;
      logic [31:0] seq_num;
      logic [31:0] ack_num;
      logic [3:0]  data_offset;
      logic [3:0]  reserved;
      logic [7:0]  flags;
      logic [15:0] win_size;
      logic [15:0] chksum;
      logic [15:0] urg_ptr;
   } tcp_hdr_t;

   typedef struct packed {
      logic [IP_ADDR_WIDTH-1:0]                src_ip;
      logic [IP_ADDR_WIDTH-1:0]                dst_ip;
      tcp_hdr_t                                tcp_hdr;
      logic [PAYLOAD_BUF_ENTRY_ADDR_WIDTH-1:0] payload_addr;
      logic [PAYLOAD_BUF_ENTRY_LEN_WIDTH-1:0]  payload_len;
   } echo_entry_t;

   // Sequence space consumed by a segment: payload bytes, plus SYN and FIN
   function automatic logic [31:0] ack_incr(input logic [7:0] flags,
                                            input logic [PAYLOAD_BUF_ENTRY_LEN_WIDTH-1:0] len);
      return 32'(len) + 32'(flags[FLAG_SYN]) + 32'(flags[FLAG_FIN]);
   endfunction

endpackage

// File: rtl/tcp_echo_fifo.sv
// Generic synchronous FIFO, DEPTH entries (power of two) of W bits.
// Ports: push_i/push_dat_i write, pop_i/pop_dat_o read head (combinational),
// full_o/empty_o/occupancy_o status. Push ignored when full, pop when empty.
module tcp_echo_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push_i,
   input  logic [W-1:0]           push_dat_i,
   input  logic                   pop_i,
   output logic [W-1:0]           pop_dat_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] occupancy_o
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);
   localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          push_ok, pop_ok;

   assign full_o      = (cnt_q == (AW+1)'(DEPTH));
   assign empty_o     = (cnt_q == '0);
   assign occupancy_o = cnt_q;
   assign pop_dat_o   = mem_q[rd_ptr_q];
   assign push_ok     = push_i && !full_o;
   assign pop_ok      = pop_i && !empty_o;

   // Pointers wrap naturally because DEPTH is a power of two
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (push_ok && !pop_ok) cnt_d = cnt_q + CNT_ONE;
      else if (pop_ok && !push_ok) cnt_d = cnt_q - CNT_ONE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage needs no reset; validity is tracked by the count alone
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
   end

endmodule

// File: rtl/tcp_echo_responder.sv
// TCP echo responder: queues eligible RX segments and emits one ACK response per
// entry with swapped tuple. Latency >= 1 cycle, 1 response/cycle sustained.
// RX ready = queue not full; TX holds valid/data until accepted.
// Ports: parser_rx_* segment in (val/rdy), tcp_parser_tx_* response out (val/rdy),
// resp_cnt/drop_cnt statistics, occupancy queue fill.
// Build option TCP_ECHO_CTRL_ACK_EN: answer zero-length SYN/FIN segments with a pure ACK.
module tcp_echo_responder
   import tcp_echo_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = 32
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic                                    parser_rx_tcp_hdr_val,
   output logic                                    tcp_parser_rx_rdy,
   input  logic [IP_ADDR_WIDTH-1:0]                parser_rx_tcp_src_ip,
   input  logic [IP_ADDR_WIDTH-1:0]                parser_rx_tcp_dst_ip,
   input  logic [TCP_HEADER_WIDTH-1:0]             parser_rx_tcp_tcp_hdr,
   input  logic [PAYLOAD_BUF_ENTRY_ADDR_WIDTH-1:0] parser_rx_tcp_payload_addr,
   input  logic [PAYLOAD_BUF_ENTRY_LEN_WIDTH-1:0]  parser_rx_tcp_payload_len,
   output logic                                    tcp_parser_tx_val,
   input  logic                                    parser_tx_tcp_rdy,
   output logic [IP_HEADER_WIDTH-1:0]              tcp_parser_tx_ip_header,
   output logic [TCP_HEADER_WIDTH-1:0]             tcp_parser_tx_tcp_header,
   output logic [PAYLOAD_BUF_ENTRY_ADDR_WIDTH-1:0] tcp_parser_tx_payload_addr,
   output logic [PAYLOAD_BUF_ENTRY_LEN_WIDTH-1:0]  tcp_parser_tx_payload_len,
   output logic [CNT_W-1:0]                        resp_cnt,
   output logic [CNT_W-1:0]                        drop_cnt,
   output logic [$clog2(DEPTH):0]                  occupancy
);
   localparam int EW = $bits(echo_entry_t);

   tcp_hdr_t    rx_hdr;
   echo_entry_t rx_entry, head;
   logic [EW-1:0] head_raw;
   logic        rx_fire, tx_fire, rx_elig, full, empty;
   logic [CNT_W-1:0] resp_cnt_q, resp_cnt_d, drop_cnt_q, drop_cnt_d;
   ip_hdr_t     tx_ip;
   tcp_hdr_t    tx_tcp;

   assign rx_hdr = tcp_hdr_t'(parser_rx_tcp_tcp_hdr);

   // Zero-length segments with no SYN/FIN are never answered, which keeps two
   // responders from bouncing bare ACKs at each other forever.
`ifdef TCP_ECHO_CTRL_ACK_EN
   assign rx_elig = (parser_rx_tcp_payload_len != '0) || rx_hdr.flags[FLAG_SYN] || rx_hdr.flags[FLAG_FIN];
`else
   assign rx_elig = (parser_rx_tcp_payload_len != '0);
`endif

   // No bypass: a full queue stalls RX even if TX pops in the same cycle
   assign tcp_parser_rx_rdy = !full;
   assign tcp_parser_tx_val = !empty;
   assign rx_fire = parser_rx_tcp_hdr_val && tcp_parser_rx_rdy;
   assign tx_fire = tcp_parser_tx_val && parser_tx_tcp_rdy;

   always_comb begin
      rx_entry              = '0;
      rx_entry.src_ip       = parser_rx_tcp_src_ip;
      rx_entry.dst_ip       = parser_rx_tcp_dst_ip;
      rx_entry.tcp_hdr      = rx_hdr;
      rx_entry.payload_addr = parser_rx_tcp_payload_addr;
      rx_entry.payload_len  = parser_rx_tcp_payload_len;
   end

   tcp_echo_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (rx_fire && rx_elig),
      .push_dat_i  (rx_entry),
      .pop_i       (tx_fire),
      .pop_dat_o   (head_raw),
      .full_o      (full),
      .empty_o     (empty),
      .occupancy_o (occupancy)
   );

   assign head = echo_entry_t'(head_raw);

   // Response header is a pure function of the queue head, so it stays stable
   // for as long as the head is not popped.
   always_comb begin
      tx_ip             = '0;
      tx_ip.version     = 4'd4;
      tx_ip.ihl         = 4'd5;
      tx_ip.tot_len     = RESP_HDR_BYTES + 16'(head.payload_len);
      tx_ip.id          = RESP_IP_ID;
      tx_ip.ttl         = '1;
      tx_ip.protocol    = 8'(IPPROTO_TCP);
      tx_ip.src_addr    = head.dst_ip;
      tx_ip.dst_addr    = head.src_ip;

      tx_tcp             = '0;
      tx_tcp.src_port    = head.tcp_hdr.dst_port;
      tx_tcp.dst_port    = head.tcp_hdr.src_port;
      tx_tcp.seq_num     = head.tcp_hdr.ack_num;
      tx_tcp.ack_num     = head.tcp_hdr.seq_num + ack_incr(head.tcp_hdr.flags, head.payload_len);
      tx_tcp.data_offset = 4'(TCP_HEADER_BYTES / 4);
      tx_tcp.flags       = (head.payload_len != '0) ? RESP_FLAGS_DATA : RESP_FLAGS_CTRL;
      tx_tcp.win_size    = '1;
   end

   assign tcp_parser_tx_ip_header    = tx_ip;
   assign tcp_parser_tx_tcp_header   = tx_tcp;
   assign tcp_parser_tx_payload_addr = head.payload_addr;
   assign tcp_parser_tx_payload_len  = head.payload_len;

   always_comb begin
      resp_cnt_d = resp_cnt_q;
      drop_cnt_d = drop_cnt_q;
      if (tx_fire)             resp_cnt_d = resp_cnt_q + CNT_W'(1);
      if (rx_fire && !rx_elig) drop_cnt_d = drop_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         resp_cnt_q <= '0;
         drop_cnt_q <= '0;
      end else begin
         resp_cnt_q <= resp_cnt_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign resp_cnt = resp_cnt_q;
   assign drop_cnt = drop_cnt_q;

endmodule
